instr_mem_responder: RTL and testbench

- Responder side of the fetch interface: accepts word-addressed PC fetch requests from the instruction fetch unit and returns the 32-bit instruction word after a configurable wait-state latency.
- Holds the program in an internal word array, written through a load port.
- Supports backpressure on the response side, a flush for branch/jump redirects, and out-of-range fault reporting.

---
 rtl/instr_mem_responder_if.sv | 23 ++
 rtl/instr_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_instr_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
// Fetch-side handshake bundle between the instruction fetch unit (master)
// and the instruction memory responder (slave).
interface instr_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        req_flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_fault;

    modport master (
        output req_valid, req_pc, req_flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
    );

    modport slave (
        input  req_valid, req_pc, req_flush, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: answers word-addressed fetches from an internal
// program array after WAIT_STATES extra cycles, with flush and range-fault support.
module instr_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_mem_responder_if.slave  bus,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic [15:0]           resp_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    logic [31:0] mem_array [DEPTH];

    state_e      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic [31:0] pc_q,        pc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_instr_q, rsp_instr_d;
    logic [31:0] rsp_pc_q,    rsp_pc_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [15:0] count_q,     count_d;
    logic        live_q;

    logic        req_ready_s;
    logic        accept_s;
    logic        load_rsp_s;
    logic [31:0] read_pc_s;

    // Program load port; the array read below sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_array[load_addr] <= load_data;
        end
    end

    // Next-state, handshake and response capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_instr_d = rsp_instr_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_fault_d = rsp_fault_q;
        count_d     = count_q;
        req_ready_s = 1'b0;
        accept_s    = 1'b0;
        load_rsp_s  = 1'b0;
        read_pc_s   = pc_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_s = live_q & ~bus.req_flush;
                accept_s    = bus.req_valid & req_ready_s;
            end
            ST_WAIT: begin
                if (bus.req_flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    load_rsp_s = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                req_ready_s = live_q & bus.rsp_ready & ~bus.req_flush;
                if (bus.rsp_ready) begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end else begin
                        count_d = count_q;
                    end
                    accept_s    = bus.req_valid & req_ready_s;
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (bus.req_flush) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // A new accept overrides whatever the current state decided.
        if (accept_s) begin
            pc_d = bus.req_pc;
            if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_INIT;
            end else begin
                state_d    = ST_RESP;
                load_rsp_s = 1'b1;
                read_pc_s  = bus.req_pc;
            end
        end else begin
            pc_d = pc_q;
        end

        if (load_rsp_s) begin
            rsp_valid_d = 1'b1;
            rsp_pc_d    = read_pc_s;
            if (read_pc_s >= 32'(DEPTH)) begin
                rsp_instr_d = 32'h0000_0000;
                rsp_fault_d = 1'b1;
            end else begin
                rsp_instr_d = mem_array[read_pc_s[ADDR_WIDTH-1:0]];
                rsp_fault_d = 1'b0;
            end
        end else begin
            rsp_pc_d = rsp_pc_q;
        end
    end

    // State and output registers; live_q keeps req_ready low while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            pc_q        <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= 32'd0;
            rsp_pc_q    <= 32'd0;
            rsp_fault_q <= 1'b0;
            count_q     <= 16'd0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_fault_q <= rsp_fault_d;
            count_q     <= count_d;
            live_q      <= 1'b1;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_pc    = rsp_pc_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign resp_count    = count_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: directed scenarios plus a
// randomized fetch stream checked against an array-based reference model.
module tb_instr_mem_responder;
    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [15:0] resp_count;

    instr_mem_responder_if bus();

    instr_mem_responder #(.DEPTH(256), .ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .bus(bus), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .resp_count(resp_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_model [256];
    int          count_model = 0;
    logic [31:0] stream_pcs [$];

    task automatic test_reset();
        reset = 1'b0; load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;
        bus.req_valid = 1'b1; bus.req_pc = 32'd0; bus.req_flush = 1'b0; bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.rsp_instr !== 32'd0) begin n_err++; $display("FAIL reset_rsp_instr: got %h want 0", bus.rsp_instr); end
        n_cmp++; if (bus.rsp_pc !== 32'd0) begin n_err++; $display("FAIL reset_rsp_pc: got %h want 0", bus.rsp_pc); end
        n_cmp++; if (bus.rsp_fault !== 1'b0) begin n_err++; $display("FAIL reset_rsp_fault: got %b want 0", bus.rsp_fault); end
        n_cmp++; if (resp_count !== 16'd0) begin n_err++; $display("FAIL reset_resp_count: got %0d want 0", resp_count); end
        bus.req_valid = 1'b0;
        reset = 1'b1;
        count_model = 0;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL idle_req_ready: got %b want 1", bus.req_ready); end
        bus.req_flush = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL idle_flush_req_ready: got %b want 0", bus.req_ready); end
        bus.req_flush = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = (i < 4) ? 32'((i + 1) * 17) : $urandom;
            mem_model[i] = load_data;
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_pc = 32'd2; bus.rsp_ready = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b want 1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_wait_valid: got %b want 0", bus.rsp_valid); end
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_instr !== 32'h33) begin n_err++; $display("FAIL single_instr: got %h want 33", bus.rsp_instr); end
        n_cmp++; if (bus.rsp_pc !== 32'd2) begin n_err++; $display("FAIL single_pc: got %h want 2", bus.rsp_pc); end
        n_cmp++; if (bus.rsp_fault !== 1'b0) begin n_err++; $display("FAIL single_fault: got %b want 0", bus.rsp_fault); end
        count_model++;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_done_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (resp_count !== 16'(count_model)) begin n_err++; $display("FAIL single_count: got %0d want %0d", resp_count, count_model); end
    endtask

    // Streams stream_pcs through the DUT; the model fixes each response's
    // value at the edge it becomes valid (old data if loaded on that edge).
    task automatic run_stream(input bit rand_ready, input bit rand_load, input bit check_spacing);
        int idx = 0, done = 0, cyc = 0, last_new = -1;
        bit will_acc = 0, will_hs = 0, prev_v = 0, lvalid = 0, newly;
        logic [7:0]  lold_addr = 8'd0;
        logic [31:0] lold = 32'd0, exp_instr = 32'd0, exp_pc = 32'd0, pc;
        logic        exp_fault = 1'b0;
        int acc_cyc [$];
        while (done < stream_pcs.size() && cyc < 200 * stream_pcs.size() + 20) begin
            @(negedge clk);
            cyc++;
            if (will_acc) idx++;
            if (will_hs) done++;
            newly = bus.rsp_valid && (!prev_v || will_hs);
            if (newly) begin
                n_cmp++;
                if (done >= stream_pcs.size() || acc_cyc.size() == 0) begin
                    n_err++; $display("FAIL stream_spurious: got rsp_valid 1 want 0 at cycle %0d", cyc);
                end else begin
                    pc        = stream_pcs[done];
                    exp_pc    = pc;
                    exp_fault = (pc >= 32'd256);
                    exp_instr = exp_fault ? 32'd0 :
                                ((lvalid && lold_addr == pc[7:0]) ? lold : mem_model[pc[7:0]]);
                    if (cyc != acc_cyc[0] + WS + 1) begin
                        n_err++; $display("FAIL stream_latency: got cycle %0d want %0d", cyc, acc_cyc[0] + WS + 1);
                    end
                    void'(acc_cyc.pop_front());
                    if (check_spacing && last_new >= 0) begin
                        n_cmp++;
                        if (cyc - last_new != 2) begin n_err++; $display("FAIL stream_spacing: got %0d want 2", cyc - last_new); end
                    end
                    last_new = cyc;
                end
            end
            if (bus.rsp_valid) begin
                n_cmp++; if (bus.rsp_instr !== exp_instr) begin n_err++; $display("FAIL stream_instr: got %h want %h", bus.rsp_instr, exp_instr); end
                n_cmp++; if (bus.rsp_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc: got %h want %h", bus.rsp_pc, exp_pc); end
                n_cmp++; if (bus.rsp_fault !== exp_fault) begin n_err++; $display("FAIL stream_fault: got %b want %b", bus.rsp_fault, exp_fault); end
            end
            n_cmp++; if (resp_count !== 16'(count_model)) begin n_err++; $display("FAIL stream_count: got %0d want %0d", resp_count, count_model); end
            prev_v = bus.rsp_valid;
            if (done >= stream_pcs.size()) break;
            bus.req_valid = (idx < stream_pcs.size());
            bus.req_pc    = (idx < stream_pcs.size()) ? stream_pcs[idx] : 32'd0;
            bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            load_en       = rand_load ? ($urandom_range(0, 3) == 0) : 1'b0;
            load_addr     = 8'($urandom_range(0, 7));
            load_data     = $urandom;
            #1;
            will_acc = bus.req_valid && bus.req_ready;
            will_hs  = bus.rsp_valid && bus.rsp_ready;
            if (will_acc) acc_cyc.push_back(cyc);
            if (will_hs) count_model++;
            lvalid = load_en;
            if (load_en) begin
                lold_addr = load_addr;
                lold      = mem_model[load_addr];
                mem_model[load_addr] = load_data;
            end
        end
        n_cmp++; if (done != stream_pcs.size()) begin n_err++; $display("FAIL stream_timeout: got %0d responses want %0d", done, stream_pcs.size()); end
        load_en = 1'b0; bus.req_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int start = count_model;
        stream_pcs = '{32'd0, 32'd1, 32'd2, 32'd3};
        run_stream(1'b0, 1'b0, 1'b1);
        n_cmp++; if (resp_count !== 16'(start + 4)) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", resp_count, start + 4); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_i = mem_model[1];
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_pc = 32'd1; bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_pc = 32'd2;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_wait_valid: got %b want 0", bus.rsp_valid); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", bus.rsp_valid); end
            n_cmp++; if (bus.rsp_instr !== exp_i) begin n_err++; $display("FAIL stall_instr: got %h want %h", bus.rsp_instr, exp_i); end
            n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL stall_req_ready: got %b want 0", bus.req_ready); end
            load_en = (k == 1); load_addr = 8'd1; load_data = $urandom;
            if (k == 1) mem_model[1] = load_data;
        end
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        count_model++;
        @(negedge clk);
        n_cmp++; if (resp_count !== 16'(count_model)) begin n_err++; $display("FAIL stall_count: got %0d want %0d", resp_count, count_model); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_done_valid: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_fault();
        stream_pcs = '{32'h100, $urandom | 32'h0000_0100, 32'hFFFF_FFFF, 32'd5};
        run_stream(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_pc = 32'd3; bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_flush = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL flush_wait_ready: got %b want 0", bus.req_ready); end
        @(negedge clk);
        bus.req_flush = 1'b0;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_wait_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (resp_count !== 16'(count_model)) begin n_err++; $display("FAIL flush_wait_count: got %0d want %0d", resp_count, count_model); end
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle_ready: got %b want 1", bus.req_ready); end
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_late_valid: got %b want 0", bus.rsp_valid); end
        // Flush while a response is stalled.
        bus.req_valid = 1'b1; bus.req_pc = 32'd2; bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL flush_resp_valid: got %b want 1", bus.rsp_valid); end
        bus.req_flush = 1'b1;
        @(negedge clk);
        bus.req_flush = 1'b0;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_resp_drop: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (resp_count !== 16'(count_model)) begin n_err++; $display("FAIL flush_resp_count: got %0d want %0d", resp_count, count_model); end
        // Flush coinciding with a handshake: counted, no new accept.
        bus.req_valid = 1'b1; bus.req_pc = 32'd0; bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_pc = 32'd1;
        @(negedge clk);
        n_cmp++; if (bus.rsp_instr !== mem_model[0]) begin n_err++; $display("FAIL flush_hs_instr: got %h want %h", bus.rsp_instr, mem_model[0]); end
        bus.req_flush = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL flush_hs_ready: got %b want 0", bus.req_ready); end
        count_model++;
        @(negedge clk);
        bus.req_flush = 1'b0; bus.req_valid = 1'b0;
        n_cmp++; if (resp_count !== 16'(count_model)) begin n_err++; $display("FAIL flush_hs_count: got %0d want %0d", resp_count, count_model); end
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_hs_noaccept: got %b want 0", bus.rsp_valid); end
        stream_pcs = '{32'd0};
        run_stream(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_pc = 32'd3; bus.rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0; bus.req_valid = 1'b0;
        #1;
        count_model = 0;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (resp_count !== 16'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", resp_count); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_hold_valid: got %b want 0", bus.rsp_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after_valid: got %b want 0", bus.rsp_valid); end
        stream_pcs = '{32'd3};
        run_stream(1'b0, 1'b0, 1'b0);
        n_cmp++; if (resp_count !== 16'd1) begin n_err++; $display("FAIL rstmid_final_count: got %0d want 1", resp_count); end
    endtask

    task automatic test_random();
        int r;
        stream_pcs.delete();
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      stream_pcs.push_back(32'($urandom_range(0, 7)));
            else if (r < 85) stream_pcs.push_back(32'($urandom_range(8, 255)));
            else             stream_pcs.push_back($urandom | 32'h0000_0100);
        end
        run_stream(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        load_program();
        test_single();
        test_back_to_back();
        test_stall();
        test_fault();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
